// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT stage sequencer and its consumers.
package fft_ctrl_pkg;

   localparam int unsigned CNT_W   = 6;
   localparam int unsigned STAGE_W = 3;

   // stage_num codes outside the compute range
   localparam logic [STAGE_W-1:0] STAGE_LOAD   = 3'd0;
   localparam logic [STAGE_W-1:0] STAGE_UNLOAD = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMPUTE,
      UNLOAD
   } seq_state_t;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control, handshake and select bus between the FFT sequencer and the datapath.
interface fft_stage_sequencer_if;
   import fft_ctrl_pkg::*;

   logic               start;
   logic               abort;
   logic               hold;
   logic               in_valid;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [CNT_W-1:0]   counter;
   logic [STAGE_W-1:0] stage_num;
   logic               stage_start;
   logic               busy;
   logic               done;

   // Sequencer side
   modport master (
      input  start, abort, hold, in_valid, out_ready,
      output in_ready, out_valid, counter, stage_num, stage_start, busy, done
   );

   // Controller / datapath side
   modport slave (
      output start, abort, hold, in_valid, out_ready,
      input  in_ready, out_valid, counter, stage_num, stage_start, busy, done
   );

endinterface

// File: rtl/fft_stage_sequencer.sv
// Phase sequencer for the pipelined FFT: LOAD, fixed-length COMPUTE passes, UNLOAD.
module fft_stage_sequencer
   import fft_ctrl_pkg::*;
#(
   parameter int unsigned N_POINTS           = 32,
   parameter int unsigned CYCLES_PER_STAGE   = 64,
   parameter int unsigned NUM_COMPUTE_STAGES = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   fft_stage_sequencer_if.master bus
);

   localparam logic [CNT_W-1:0]   LAST_POINT = CNT_W'(N_POINTS - 1);
   localparam logic [CNT_W-1:0]   LAST_CYCLE = CNT_W'(CYCLES_PER_STAGE - 1);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_COMPUTE_STAGES);

   seq_state_t         state_q, state_d;
   logic [CNT_W-1:0]   counter_q, counter_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               stage_start_q, stage_start_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic in_accept;
   logic out_accept;

   assign in_accept  = bus.in_valid & in_ready_q;
   assign out_accept = out_valid_q & bus.out_ready;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         counter_q     <= '0;
         stage_q       <= STAGE_LOAD;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         stage_start_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         counter_q     <= counter_d;
         stage_q       <= stage_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         stage_start_q <= stage_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   // Next-state: abort overrides every phase transition
   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (in_accept && counter_q == LAST_POINT) state_d = COMPUTE;
            COMPUTE: if (!bus.hold && counter_q == LAST_CYCLE && stage_q == LAST_STAGE)
                        state_d = UNLOAD;
            UNLOAD:  if (out_accept && counter_q == LAST_POINT) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Next output values: counter/stage advance rules per phase, flags from next state
   always_comb begin
      counter_d     = counter_q;
      stage_d       = stage_q;
      stage_start_d = 1'b0;
      done_d        = 1'b0;
      if (bus.abort) begin
         counter_d = '0;
         stage_d   = STAGE_LOAD;
      end else begin
         case (state_q)
            IDLE: begin
               counter_d = '0;
               stage_d   = STAGE_LOAD;
            end
            LOAD: begin
               if (in_accept) begin
                  if (counter_q == LAST_POINT) begin
                     counter_d     = '0;
                     stage_d       = STAGE_W'(1);
                     stage_start_d = 1'b1;
                  end else begin
                     counter_d = counter_q + CNT_W'(1);
                  end
               end
            end
            COMPUTE: begin
               if (!bus.hold) begin
                  if (counter_q == LAST_CYCLE) begin
                     counter_d = '0;
                     if (stage_q == LAST_STAGE) begin
                        stage_d = STAGE_UNLOAD;
                     end else begin
                        stage_d       = stage_q + STAGE_W'(1);
                        stage_start_d = 1'b1;
                     end
                  end else begin
                     counter_d = counter_q + CNT_W'(1);
                  end
               end
            end
            UNLOAD: begin
               if (out_accept) begin
                  if (counter_q == LAST_POINT) begin
                     counter_d = '0;
                     stage_d   = STAGE_LOAD;
                     done_d    = 1'b1;
                  end else begin
                     counter_d = counter_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               counter_d = '0;
               stage_d   = STAGE_LOAD;
            end
         endcase
      end
      in_ready_d  = (state_d == LOAD);
      out_valid_d = (state_d == UNLOAD);
      busy_d      = (state_d != IDLE);
   end

   assign bus.counter     = counter_q;
   assign bus.stage_num   = stage_q;
   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.stage_start = stage_start_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule
